// File: rtl/amoled_row_scheduler.sv
// Row-sequential AMOLED compensation scheduler: INIT -> SCAN per row, with emission held on programmed rows.
// Optional AMOLED_SCHED_AUTORUN_EN: free-run frames back to back after the first start.

module amoled_row_drv (
  input  logic in_init,
  input  logic in_scan,
  input  logic lit,
  output logic vinit,
  output logic vcomp,
  output logic vscan,
  output logic vem1,
  output logic vem2
);
  logic active;

  always_comb begin
    active = in_init | in_scan;
    vinit  = in_init;
    vcomp  = active;
    vscan  = in_scan;
    vem1   = lit & ~active;
    vem2   = lit & ~active;
  end
endmodule

module amoled_row_scheduler #(
  parameter int ROWS   = 8,
  parameter int CNT_W  = 16,
  parameter int T_INIT = 2000,
  parameter int T_SCAN = 3000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    frame_done,
  output logic [$clog2(ROWS)-1:0] row_idx,
  output logic [ROWS-1:0]         vinit,
  output logic [ROWS-1:0]         vcomp,
  output logic [ROWS-1:0]         vscan,
  output logic [ROWS-1:0]         vem1,
  output logic [ROWS-1:0]         vem2
);
  localparam int RW = $clog2(ROWS);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(T_INIT - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(T_SCAN - 1);
  localparam logic [RW-1:0]    ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, INIT, SCAN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    row_q, row_d;
  logic [ROWS-1:0]  lit_q, lit_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic [ROWS-1:0]  vinit_q, vinit_d, vcomp_q, vcomp_d, vscan_q, vscan_d;
  logic [ROWS-1:0]  vem1_q, vem1_d, vem2_q, vem2_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    lit_d        = lit_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          row_d   = '0;
          cnt_d   = '0;
          lit_d[0] = 1'b0;
        end
      end
      INIT: begin
        if (cnt_q == INIT_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d        = '0;
          lit_d[row_q] = 1'b1;
          if (row_q == ROW_LAST) begin
            frame_done_d = 1'b1;
            row_d        = '0;
`ifdef AMOLED_SCHED_AUTORUN_EN
            state_d  = INIT;
            lit_d[0] = 1'b0;
`else
            state_d  = IDLE;
`endif
          end else begin
            // Row about to be programmed stops emitting from the same edge.
            state_d             = INIT;
            row_d               = row_q + 1'b1;
            lit_d[row_q + 1'b1] = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        row_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Line drivers are decoded from next-state so every output is a plain flop.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic sel;
    assign sel = (row_d == RW'(r));
    amoled_row_drv u_drv (
      .in_init (sel && state_d == INIT),
      .in_scan (sel && state_d == SCAN),
      .lit     (lit_d[r]),
      .vinit   (vinit_d[r]),
      .vcomp   (vcomp_d[r]),
      .vscan   (vscan_d[r]),
      .vem1    (vem1_d[r]),
      .vem2    (vem2_d[r])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      lit_q        <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      vinit_q      <= '0;
      vcomp_q      <= '0;
      vscan_q      <= '0;
      vem1_q       <= '0;
      vem2_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      lit_q        <= lit_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      vinit_q      <= vinit_d;
      vcomp_q      <= vcomp_d;
      vscan_q      <= vscan_d;
      vem1_q       <= vem1_d;
      vem2_q       <= vem2_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign row_idx    = row_q;
  assign vinit      = vinit_q;
  assign vcomp      = vcomp_q;
  assign vscan      = vscan_q;
  assign vem1       = vem1_q;
  assign vem2       = vem2_q;
endmodule

// File: tb/tb_amoled_row_scheduler.sv
// Directed bench for amoled_row_scheduler: ROWS=4, T_INIT=3, T_SCAN=5 (8 cycles per row, 32 per frame).

module tb_amoled_row_scheduler;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       busy, frame_done;
  logic [1:0] row_idx;
  logic [3:0] vinit, vcomp, vscan, vem1, vem2;

  int checks = 0;
  int errors = 0;

  amoled_row_scheduler #(.ROWS(4), .CNT_W(16), .T_INIT(3), .T_SCAN(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .row_idx    (row_idx),
    .vinit      (vinit),
    .vcomp      (vcomp),
    .vscan      (vscan),
    .vem1       (vem1),
    .vem2       (vem2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         frm;
    int         cyc;
    logic       busy;
    logic       fd;
    logic [1:0] row;
    logic [3:0] vi, vc, vs, ve;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exclusivity(input int c);
    logic [3:0] sw;
    sw = vinit | vscan;
    chk($sformatf("excl_c%0d", c),
        {31'd0, ($countones(sw) <= 1) && ((sw & vem1) == 4'd0) && (vem1 === vem2)}, 32'd1);
  endtask

  // Walks cycles 0..33 after the start edge, comparing table rows of frame set `frm`.
  task automatic run_frame(input int frm, input bit pulses, input string tag);
    for (int c = 0; c <= 33; c++) begin
      foreach (tbl[i]) begin
        if (tbl[i].frm == frm && tbl[i].cyc == c)
          chk($sformatf("%s_c%0d", tag, c),
              {8'd0, busy, frame_done, row_idx, vinit, vcomp, vscan, vem1, vem2},
              {8'd0, tbl[i].busy, tbl[i].fd, tbl[i].row, tbl[i].vi, tbl[i].vc,
               tbl[i].vs, tbl[i].ve, tbl[i].ve});
      end
      exclusivity(c);
      if (pulses && (c == 5 || c == 20)) start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Frame 1: lit starts all zero.
    tbl.push_back('{1,  0, 1, 0, 0, 4'h1, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{1,  2, 1, 0, 0, 4'h1, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{1,  3, 1, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0});
    tbl.push_back('{1,  7, 1, 0, 0, 4'h0, 4'h1, 4'h1, 4'h0});
    tbl.push_back('{1,  8, 1, 0, 1, 4'h2, 4'h2, 4'h0, 4'h1});
    tbl.push_back('{1, 11, 1, 0, 1, 4'h0, 4'h2, 4'h2, 4'h1});
    tbl.push_back('{1, 16, 1, 0, 2, 4'h4, 4'h4, 4'h0, 4'h3});
    tbl.push_back('{1, 24, 1, 0, 3, 4'h8, 4'h8, 4'h0, 4'h7});
    tbl.push_back('{1, 26, 1, 0, 3, 4'h8, 4'h8, 4'h0, 4'h7});
    tbl.push_back('{1, 27, 1, 0, 3, 4'h0, 4'h8, 4'h8, 4'h7});
    tbl.push_back('{1, 31, 1, 0, 3, 4'h0, 4'h8, 4'h8, 4'h7});
    tbl.push_back('{1, 32, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{1, 33, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF});
    // Later frames: every row emits except the one being programmed.
    tbl.push_back('{2,  0, 1, 0, 0, 4'h1, 4'h1, 4'h0, 4'hE});
    tbl.push_back('{2,  3, 1, 0, 0, 4'h0, 4'h1, 4'h1, 4'hE});
    tbl.push_back('{2,  8, 1, 0, 1, 4'h2, 4'h2, 4'h0, 4'hD});
    tbl.push_back('{2, 11, 1, 0, 1, 4'h0, 4'h2, 4'h2, 4'hD});
    tbl.push_back('{2, 16, 1, 0, 2, 4'h4, 4'h4, 4'h0, 4'hB});
    tbl.push_back('{2, 24, 1, 0, 3, 4'h8, 4'h8, 4'h0, 4'h7});
    tbl.push_back('{2, 27, 1, 0, 3, 4'h0, 4'h8, 4'h8, 4'h7});
    tbl.push_back('{2, 31, 1, 0, 3, 4'h0, 4'h8, 4'h8, 4'h7});
    tbl.push_back('{2, 32, 0, 1, 0, 4'h0, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{2, 33, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'hF});

    #12;
    chk("reset_state", {8'd0, busy, frame_done, row_idx, vinit, vcomp, vscan, vem1, vem2}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    tick();
    chk("idle_no_start", {31'd0, busy}, 32'd0);

    do_start();
    run_frame(1, 1'b0, "frame1");
    do_start();
    run_frame(2, 1'b0, "frame2");
    do_start();
    run_frame(2, 1'b1, "ignored_start");

`ifdef AMOLED_SCHED_AUTORUN_EN
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    do_start();
    for (int c = 0; c <= 100; c++) begin
      chk($sformatf("auto_busy_c%0d", c), {31'd0, busy}, 32'd1);
      chk($sformatf("auto_fd_c%0d", c), {31'd0, frame_done},
          {31'd0, (c == 32 || c == 64 || c == 96)});
      if (c == 32) chk("auto_row0_restart", {28'd0, row_idx, vinit[0], vscan[0]}, 32'b0010);
      tick();
    end
`else
    // start held high: one IDLE cycle between frames.
    start = 1'b1;
    tick();
    for (int c = 0; c <= 33; c++) begin
      if (c == 32) chk("held_c32", {30'd0, busy, frame_done}, 32'b01);
      if (c == 33) chk("held_c33", {27'd0, busy, frame_done, vinit[0], vem1[0], 1'b0}, 32'b10100);
      tick();
    end
    start = 1'b0;
`endif

    // Asynchronous reset mid-SCAN of row 2 (row 2 SCAN occupies cycles 19..23).
    reset = 1'b0;
    #2;
    @(negedge clk);
    reset = 1'b1;
    do_start();
    for (int c = 0; c < 20; c++) tick();
    chk("pre_reset_scan2", {28'd0, row_idx, vscan[2], busy}, 32'b1011);
    reset = 1'b0;
    #1;
    chk("async_reset", {8'd0, busy, frame_done, row_idx, vinit, vcomp, vscan, vem1, vem2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("post_reset_idle_c%0d", c),
          {8'd0, busy, frame_done, row_idx, vinit, vcomp, vscan, vem1, vem2}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/amoled_row_scheduler.md
# amoled_row_scheduler

Frame-level sequencer for a ROWS-line AMOLED pixel array. It sequences each row through the per-pixel compensation waveform: initialisation, then threshold compensation with data scan, then emission. It drives one vinit/vcomp/vscan/vem1/vem2 line per row. It sits between the display timing controller (start/busy/frame_done) and the panel row drivers, replacing per-pixel free-running waveform generators with one shared, row-sequential schedule.

## Interface
- ROWS, 8: number of panel rows; ≥2.
- CNT_W, 16: phase-counter width.
- T_INIT, 2000: cycles per row in INIT phase; 1..2^CNT_W-1.
- T_SCAN, 3000: cycles per row in SCAN phase; 1..2^CNT_W-1.
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  frame request; sampled only in IDLE.
- busy  output  1  high while a frame is being sequenced.
- frame_done  output  1  one-cycle pulse at end of each frame.
- row_idx  output  $clog2(ROWS)  row currently being programmed (0 in IDLE).
- vinit  output  ROWS  per-row initialisation switch.
- vcomp  output  ROWS  per-row compensation switch.
- vscan  output  ROWS  per-row data-scan switch.
- vem1  output  ROWS  per-row emission switch 1.
- vem2  output  ROWS  per-row emission switch 2.

## Operation
- FSM states: IDLE, INIT, SCAN. Phase counter `cnt` (CNT_W bits), row register, ROWS-bit `lit` vector.
- IDLE: busy=0. start=1 -> INIT, row=0, cnt=0. start in INIT/SCAN is ignored (no queuing).
- INIT: cnt counts 0..T_INIT-1; at cnt==T_INIT-1 -> SCAN, cnt=0.
- SCAN: cnt counts 0..T_SCAN-1. At cnt==T_SCAN-1: set lit[row]. If row<ROWS-1 -> INIT, row+1. Else -> IDLE, assert frame_done.
- On entering INIT for row r, lit[r] is cleared. Other rows' lit bits are untouched, so they keep emitting.
- Per-row decode, Moore outputs from flops only:
  - Active row in INIT: vinit=1, vcomp=1, vscan=0, vem1=0, vem2=0.
  - Active row in SCAN: vinit=0, vcomp=1, vscan=1, vem1=0, vem2=0.
  - Non-active rows: vinit=vcomp=vscan=0; vem1=vem2=lit[r].
- At most one bit of vinit|vscan is high at any time. vem1/vem2 of the active row are always 0.
- lit persists across frames: after the first full frame, every row emits except the row being programmed.
- Counter arithmetic is unsigned with no wrap. Terminal compare is exact equality against the parameter, truncated to CNT_W.

## Timing
- Reset (async, reset=0): state=IDLE, cnt=0, row=0, lit=0. Outputs: busy=0, frame_done=0, row_idx=0, and vinit/vcomp/vscan/vem1/vem2 all zeros.
- Reset mid-frame: all row lines drop to 0 immediately (asynchronous). The next frame requires a new start.
- start sampled high in IDLE at edge k: from edge k, busy=1 and vinit[0]=vcomp[0]=1 for T_INIT cycles. vscan[0] is then high for T_SCAN cycles.
- Row r's INIT begins at edge k + r·(T_INIT+T_SCAN).
- The frame occupies ROWS·(T_INIT+T_SCAN) cycles. busy falls and frame_done is high for exactly one cycle starting at edge k + ROWS·(T_INIT+T_SCAN).
- lit[r] rises on the same edge row r leaves SCAN, so there is no dead cycle between the vscan fall and the vem rise.
- start held high continuously: a new frame begins on the edge after frame_done is first seen in IDLE, i.e. one IDLE cycle between frames.

## Configuration
- AMOLED_SCHED_AUTORUN_EN defined: after the last row's SCAN, the FSM goes directly to INIT row 0 with zero IDLE cycles. frame_done still pulses for one cycle and busy stays high. The free run continues until reset. start is needed only for the first frame.
- Undefined: behaviour as above; the FSM returns to IDLE after each frame.

## Test plan
- Reset check: ROWS=4, T_INIT=3, T_SCAN=5. Pulse reset low mid-SCAN of row 2 -> all row buses 0, busy=0 and row_idx=0 immediately; nothing moves until start.
- Single frame with the same parameters: start at edge 0 -> vinit[0] high at cycles 0-2, vscan[0] at 3-7, and vem1[0]=vem2[0] from cycle 8. vinit[3] is high at 24-26. frame_done is high at cycle 32 only; busy is high at 0-31.
- Second frame: start again after frame 1 -> row 0 vem drops at the start edge while rows 1-3 keep vem=1. Each row's vem goes low only during its own INIT/SCAN.
- start pulses at cycles 5 and 20 of an active frame -> ignored; frame timing is identical to the single-frame case.
- Exclusivity: over a full frame, check every cycle that popcount(vinit|vscan)≤1 and that (vscan[r]|vinit[r]) & vem1[r] == 0.
- AMOLED_SCHED_AUTORUN_EN defined, with one start -> frame_done at cycles 32, 64 and 96. busy is never low after start, and row 0 INIT restarts at cycle 32.
